// File: rtl/gelato_warp_scheduler.sv
`timescale 1ns/1ps
// Round-robin fetch scheduler: picks one eligible warp per cycle into a registered valid/ready slot.
// One-cycle grant-to-slot latency; a held slot blocks arbitration, and a granted warp stays busy until released.
module gelato_warp_scheduler #(
  parameter int WARP_NUM          = 4,
  parameter int PC_WIDTH          = 32,
  parameter int SPLIT_NUM_WIDTH   = 2,
  localparam int WARP_ID_WIDTH    = $clog2(WARP_NUM)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                rdy,
  input  logic [WARP_NUM-1:0]                 warp_valid,
  input  logic [WARP_NUM*PC_WIDTH-1:0]        warp_pc,
  input  logic [WARP_NUM*SPLIT_NUM_WIDTH-1:0] warp_split_num,
  output logic [WARP_NUM-1:0]                 warp_grant,
  output logic                                fetch_valid,
  input  logic                                fetch_ready,
  output logic [WARP_ID_WIDTH-1:0]            fetch_warp_num,
  output logic [SPLIT_NUM_WIDTH-1:0]          fetch_split_num,
  output logic [PC_WIDTH-1:0]                 fetch_pc,
  input  logic                                release_valid,
  input  logic [WARP_ID_WIDTH-1:0]            release_warp_num,
  output logic [WARP_NUM-1:0]                 busy
);

  logic                       fetch_valid_q, fetch_valid_d;
  logic [WARP_ID_WIDTH-1:0]   fetch_warp_num_q, fetch_warp_num_d;
  logic [SPLIT_NUM_WIDTH-1:0] fetch_split_num_q, fetch_split_num_d;
  logic [PC_WIDTH-1:0]        fetch_pc_q, fetch_pc_d;
  logic [WARP_NUM-1:0]        busy_q, busy_d;
  logic [WARP_ID_WIDTH-1:0]   last_grant_q, last_grant_d;

  logic [WARP_NUM-1:0]        eligible;
  logic                       slot_free;
  logic                       arb_en;
  logic                       found;
  logic [WARP_ID_WIDTH-1:0]   winner;
  logic [WARP_ID_WIDTH-1:0]   idx;
  logic [WARP_NUM-1:0]        grant_vec;

  // Eligibility uses registered busy only, so a release becomes visible one cycle later.
  always_comb begin
    eligible  = warp_valid & ~busy_q;
    slot_free = !fetch_valid_q || fetch_ready;
    arb_en    = rdy && slot_free && (|eligible);
    found     = 1'b0;
    winner    = '0;
    idx       = '0;
    for (int i = 1; i <= WARP_NUM; i++) begin
      idx = last_grant_q + WARP_ID_WIDTH'(i);
      if (!found && eligible[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    grant_vec = '0;
    if (arb_en && !rst) begin
      grant_vec[winner] = 1'b1;
    end
  end

  always_comb begin
    fetch_valid_d     = fetch_valid_q;
    fetch_warp_num_d  = fetch_warp_num_q;
    fetch_split_num_d = fetch_split_num_q;
    fetch_pc_d        = fetch_pc_q;
    busy_d            = busy_q;
    last_grant_d      = last_grant_q;
    if (release_valid) begin
      busy_d[release_warp_num] = 1'b0;
    end
    if (arb_en) begin
      fetch_valid_d     = 1'b1;
      fetch_warp_num_d  = winner;
      fetch_split_num_d = warp_split_num[winner*SPLIT_NUM_WIDTH +: SPLIT_NUM_WIDTH];
      fetch_pc_d        = warp_pc[winner*PC_WIDTH +: PC_WIDTH];
      busy_d[winner]    = 1'b1;
      last_grant_d      = winner;
    end else if (rdy && fetch_valid_q && fetch_ready) begin
      fetch_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid_q     <= 1'b0;
      fetch_warp_num_q  <= '0;
      fetch_split_num_q <= '0;
      fetch_pc_q        <= '0;
      busy_q            <= '0;
      last_grant_q      <= WARP_ID_WIDTH'(WARP_NUM - 1);
    end else begin
      fetch_valid_q     <= fetch_valid_d;
      fetch_warp_num_q  <= fetch_warp_num_d;
      fetch_split_num_q <= fetch_split_num_d;
      fetch_pc_q        <= fetch_pc_d;
      busy_q            <= busy_d;
      last_grant_q      <= last_grant_d;
    end
  end

  assign warp_grant      = grant_vec;
  assign fetch_valid     = fetch_valid_q;
  assign fetch_warp_num  = fetch_warp_num_q;
  assign fetch_split_num = fetch_split_num_q;
  assign fetch_pc        = fetch_pc_q;
  assign busy            = busy_q;

endmodule

// File: doc/gelato_warp_scheduler.md
Name: gelato_warp_scheduler

Overview:
- Per-SM fetch scheduler between the per-warp split tables and the instruction fetch stage.
- Each cycle it picks one eligible warp round-robin from the WARP_NUM candidate (pc, split-table entry) pairs.
- The pick is registered into a single valid/ready fetch slot.
- The granted warp is marked busy until downstream releases it, giving at most one instruction in flight per warp.

Parameters:
- WARP_NUM, 4, number of warps arbitrated; power of two, ≥ 2.
- PC_WIDTH, 32, program counter width.
- SPLIT_NUM_WIDTH, 2, width of a split-table entry index.
- WARP_ID_WIDTH, $clog2(WARP_NUM), derived; not overridden.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global enable; 0 freezes arbitration and the fetch slot.
- warp_valid  in  WARP_NUM  bit w: warp w presents a fetchable candidate.
- warp_pc  in  WARP_NUM*PC_WIDTH  candidate pc; slice w = [w*PC_WIDTH +: PC_WIDTH].
- warp_split_num  in  WARP_NUM*SPLIT_NUM_WIDTH  candidate split-table entry index, sliced likewise.
- warp_grant  out  WARP_NUM  combinational one-hot pulse; bit w means warp w's candidate is captured this cycle.
- fetch_valid  out  1  fetch slot holds a request.
- fetch_ready  in  1  fetch stage accepts the slot this cycle.
- fetch_warp_num  out  WARP_ID_WIDTH  warp of the slot.
- fetch_split_num  out  SPLIT_NUM_WIDTH  split-table entry of the slot.
- fetch_pc  out  PC_WIDTH  pc of the slot.
- release_valid  in  1  downstream has resolved the outstanding instruction of release_warp_num.
- release_warp_num  in  WARP_ID_WIDTH  warp to release.
- busy  out  WARP_NUM  registered per-warp in-flight flags.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - fetch_valid=0; fetch_warp_num, fetch_split_num and fetch_pc all 0.
  - busy=0.
  - Round-robin pointer last_grant=WARP_NUM-1, so warp 0 has top priority first.
  - warp_grant=0 while rst is high.
- Eligibility: eligible[w] = warp_valid[w] & ~busy[w], computed from registered busy only. A release therefore makes its warp eligible from the next cycle, not the same cycle.
- Slot free: slot_free = !fetch_valid | fetch_ready.
- Arbitration happens when rdy & slot_free & |eligible:
  - Winner is the first eligible warp scanning last_grant+1, last_grant+2, ... modulo WARP_NUM.
  - warp_grant[winner]=1 in that cycle (combinational); all other bits 0.
  - Next edge:
    - fetch_valid=1.
    - fetch_warp_num=winner.
    - fetch_pc and fetch_split_num loaded from the winner's slices.
    - busy[winner]=1.
    - last_grant=winner.
- Slot consumed with no eligible warp (rdy & fetch_valid & fetch_ready & ~|eligible): next edge fetch_valid=0; other fields hold their old values.
- Hold: fetch_valid & !fetch_ready means all fetch_* outputs stable, warp_grant=0, last_grant unchanged.
- rdy=0:
  - warp_grant=0; fetch slot and last_grant frozen.
  - fetch_ready is ignored; the handshake does not complete while rdy=0.
  - Release is still honoured.
- Release, independent of rdy: release_valid means busy[release_warp_num] clears at the next edge.
  - Releasing a non-busy warp is a no-op.
  - Grant and release in the same cycle always target different warps, because a busy warp cannot win. Both take effect.
- Back-to-back throughput: one request per cycle when fetch_ready is held high and distinct warps are eligible. A single warp can issue at most every 2 cycles (grant, release, then eligible again).
- Candidate inputs are sampled only in the grant cycle; later changes to warp_* do not alter a held slot.

Test Plan:
- Reset then warp_valid=4'b1111, fetch_ready=1, rdy=1, no releases -> grants in order warp 0,1,2,3 on consecutive cycles; busy=4'b1111 after 4 cycles; then fetch_valid=0.
- warp_valid=4'b0101, pc0=0x100, pc2=0x200, releasing each warp one cycle after its grant -> fetch_pc sequence 0x100, 0x200, 0x100, ...; warp_grant never asserts bit 1 or 3.
- Slot holds warp 1, pc=0x40; fetch_ready=0 for 5 cycles while warp_pc[1] changes to 0x80 -> fetch_pc stays 0x40, warp_grant=0 throughout; accepted on the first fetch_ready=1.
- rdy=0 for 3 cycles with fetch_ready=1, with release_valid for warp 2 in the first of them -> slot and last_grant frozen, busy[2] cleared; arbitration resumes when rdy=1.
- Release of warp 3 in the same cycle warp 0 is granted -> next edge busy[0]=1 and busy[3]=0; warp 3 is eligible the following cycle, not the current one.
- Assert rst mid-hold with fetch_valid=1 -> fetch_valid, busy and warp_grant go to 0 without a clock edge; the first grant after reset goes to warp 0.
